// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding and the data width.
// Used by both the receive and the transmit side.
package uart_pkg;
  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;
endpackage

// File: rtl/uart_rx_if.sv
// Serial line plus received-byte/status bundle for uart_rx.
// slave = receiver side, master = line driver / byte consumer.
interface uart_rx_if;
  logic                           rx;
  logic [uart_pkg::DATA_BITS-1:0] ascii_char;
  logic                           char_valid;
  logic                           frame_error;
  logic                           parity_error;
  logic                           busy;

  modport slave  (input  rx,
                  output ascii_char, char_valid, frame_error, parity_error, busy);
  modport master (output rx,
                  input  ascii_char, char_valid, frame_error, parity_error, busy);
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
// Resets to 1 so a reset looks like an idle (high) line.
module rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= 2'b11;
    else      sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];
endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames, or 8E1 when UART_RX_PARITY_EN is defined.
// Bytes leave as ascii_char with a one-cycle char_valid strobe.
module uart_rx
  import uart_pkg::*;
#(
  parameter int freq         = 200,
  parameter int UART_RX_BAUD = 20
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.slave  bus
);
  localparam int TR = freq / UART_RX_BAUD;
  localparam int CW = $clog2(TR);
  // Counter runs down to zero, so reload values are one less than the spans.
  localparam logic [CW-1:0] CNT_FULL = CW'(TR - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(TR / 2 - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  generate
    if (TR < 4) begin : g_tr_chk
      $error("uart_rx: freq/UART_RX_BAUD must be at least 4");
    end
  endgenerate

  logic                 rx_s;
  rx_state_t            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] char_q, char_d;
  logic                 cv_q, cv_d;
  logic                 fe_q, fe_d;
  logic                 tick;

  rx_sync u_sync (.clk(clk), .rst(rst), .d_i(bus.rx), .q_o(rx_s));

  assign tick = (cnt_q == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (!rx_s) state_d = START;
      START:  if (tick)  state_d = rx_s ? IDLE : DATA;
      DATA:   if (tick && bit_q == LAST_BIT)
`ifdef UART_RX_PARITY_EN
                state_d = PARITY;
      PARITY: if (tick)  state_d = STOP;
`else
                state_d = STOP;
`endif
      STOP:   if (tick)  state_d = rx_s ? IDLE : BREAK;
      BREAK:  if (rx_s)  state_d = IDLE;
      default:           state_d = IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  logic perr_q, perr_d;
  logic pe_q, pe_d;
`endif

  always_comb begin
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    char_d  = char_q;
    cv_d    = 1'b0;
    fe_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d  = perr_q;
    pe_d    = 1'b0;
`endif
    if (state_q != IDLE && state_q != BREAK)
      cnt_d = tick ? CNT_FULL : cnt_q - 1'b1;
    case (state_q)
      IDLE: begin
        cnt_d = CNT_HALF;
`ifdef UART_RX_PARITY_EN
        perr_d = 1'b0;
`endif
      end
      START: bit_d = '0;
      DATA: if (tick) begin
        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
        bit_d   = bit_q + 1'b1;
      end
`ifdef UART_RX_PARITY_EN
      // Even parity: the parity bit must equal the XOR of the data bits.
      PARITY: if (tick) perr_d = rx_s ^ (^shift_q);
`endif
      STOP: if (tick) begin
        if (rx_s) begin
          char_d = shift_q;
          cv_d   = 1'b1;
`ifdef UART_RX_PARITY_EN
          pe_d   = perr_q;
`endif
        end else begin
          fe_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      char_q  <= '0;
      cv_q    <= 1'b0;
      fe_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
      pe_q    <= 1'b0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      char_q  <= char_d;
      cv_q    <= cv_d;
      fe_q    <= fe_d;
`ifdef UART_RX_PARITY_EN
      perr_q  <= perr_d;
      pe_q    <= pe_d;
`endif
    end
  end

  assign bus.ascii_char  = char_q;
  assign bus.char_valid  = cv_q;
  assign bus.frame_error = fe_q;
  assign bus.busy        = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign bus.parity_error = pe_q;
`else
  assign bus.parity_error = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed and random frames against a frame-level model
// that predicts every strobe (cycle, kind, byte) from the line waveform.
module tb_uart_rx;
  localparam int TR = 10;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif
  // pin fall -> strobe: 2 sync + half bit + data (+parity) + stop + register
  localparam int LAT = 2 + TR / 2 + (9 + PAR_EN) * TR + 1;

  typedef struct {
    int         cyc;
    logic       cv, fe, pe;
    logic [7:0] d;
  } ev_t;

  logic clk = 0, rst_n = 0;
  int   cyc = 0, busy_cnt = 0;
  int   n_tests = 0, n_fail = 0;
  logic [7:0] last_char = 8'h00;
  ev_t  obs_q[$], exp_q[$];

  uart_rx_if bus();
  uart_rx #(.freq(200), .UART_RX_BAUD(20)) dut (.clk(clk), .rst(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.busy) busy_cnt++;
    if (bus.char_valid || bus.frame_error || bus.parity_error)
      obs_q.push_back('{cyc, bus.char_valid, bus.frame_error, bus.parity_error, bus.ascii_char});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    bus.rx = v;
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame and record what the receiver should report for it.
  task automatic send(input logic [7:0] d, input logic stop, input logic par, input int low_extra);
    int fall;
    fall = cyc;
    hold(1'b0, TR);
    for (int i = 0; i < 8; i++) hold(d[i], TR);
    if (PAR_EN != 0) hold(par, TR);
    hold(stop, TR);
    if (!stop) hold(1'b0, low_extra);
    if (stop) begin
      exp_q.push_back('{fall + LAT, 1'b1, 1'b0, (PAR_EN != 0) && (par != ^d), d});
      last_char = d;
    end else begin
      exp_q.push_back('{fall + LAT, 1'b0, 1'b1, 1'b0, last_char});
    end
  endtask

  task automatic compare_events(input string tag);
    ev_t e, o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() == 0) begin
        chk({tag, "_missing"}, 0, 1);
      end else begin
        o = obs_q.pop_front();
        chk({tag, "_cyc"}, o.cyc, e.cyc);
        chk({tag, "_kind"}, {o.cv, o.fe, o.pe}, {e.cv, e.fe, e.pe});
        chk({tag, "_byte"}, o.d, e.d);
      end
    end
    chk({tag, "_extra"}, obs_q.size(), 0);
    obs_q.delete();
  endtask

  initial begin
    logic [7:0] d;
    logic       st;
    bus.rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_char", bus.ascii_char, 8'h00);
    chk("rst_strobes", {bus.char_valid, bus.frame_error, bus.parity_error}, 0);
    chk("rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    hold(1'b1, 2 * TR);

    send(8'h41, 1'b1, 1'b0, 0);
    hold(1'b1, 2 * TR);
    compare_events("single41");
    chk("single41_busy", bus.busy, 0);

    send(8'h00, 1'b1, 1'b0, 0);
    send(8'h41, 1'b1, 1'b0, 0);
    send(8'h42, 1'b1, 1'b0, 0);
    send(8'h00, 1'b1, 1'b0, 0);
    hold(1'b1, 2 * TR);
    compare_events("b2b");

    busy_cnt = 0;
    hold(1'b0, 3);
    hold(1'b1, 3 * TR);
    compare_events("glitch");
    chk("glitch_busy_cnt", busy_cnt, TR / 2);
    chk("glitch_idle", bus.busy, 0);

    send(8'h55, 1'b0, 1'b0, 50);
    hold(1'b1, 2 * TR);
    send(8'h33, 1'b1, 1'b0, 0);
    hold(1'b1, 2 * TR);
    compare_events("break");

    hold(1'b0, TR);
    hold(1'b0, TR);
    hold(1'b1, TR);
    hold(1'b1, TR / 2);
    rst_n = 1'b0;
    bus.rx = 1'b1;
    @(negedge clk);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_char", bus.ascii_char, 8'h00);
    last_char = 8'h00;
    hold(1'b1, 2);
    rst_n = 1'b1;
    hold(1'b1, 3 * TR);
    send(8'h21, 1'b1, 1'b0, 0);
    hold(1'b1, 2 * TR);
    compare_events("midrst");
    chk("midrst_after", bus.ascii_char, 8'h21);

`ifdef UART_RX_PARITY_EN
    send(8'h03, 1'b1, 1'b1, 0);
    send(8'h03, 1'b1, 1'b0, 0);
    hold(1'b1, 2 * TR);
    compare_events("parity");
`endif

    for (int n = 0; n < 24; n++) begin
      d  = 8'($urandom);
      st = ($urandom_range(0, 4) != 0);
      send(d, st, 1'($urandom), int'($urandom_range(0, 30)));
      hold(1'b1, st ? int'($urandom_range(0, TR)) : TR + int'($urandom_range(0, TR)));
    end
    hold(1'b1, 2 * TR);
    compare_events("rand");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
